uart_rx_frame: RTL and testbench

//  UART receive framer fed by the two-stage bit synchroniser on the RX pad line; rx_in is already synchronous to clk.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_rx_sampler.sv | 47 ++++
 rtl/uart_rx_frame.sv | 143 ++++++++++++++
 tb/tb_uart_rx_frame.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART encodings, prescale constants and helpers
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    localparam logic [5:0] PRESCALE_8       = 6'd8;
    localparam logic [5:0] PRESCALE_16      = 6'd16;
    localparam logic [5:0] PRESCALE_32      = 6'd32;
    localparam logic [5:0] PRESCALE_DEFAULT = PRESCALE_8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Unsupported ratios fall back to the default so bit timing stays well defined.
    function automatic logic [5:0] legal_prescale(input logic [5:0] p);
        case (p)
            PRESCALE_8, PRESCALE_16, PRESCALE_32: return p;
            default:                              return PRESCALE_DEFAULT;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - per-bit oversampling counter with 3-sample majority vote
module uart_rx_sampler
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic       clear,
    input  logic [5:0] prescale,
    output logic       bit_val,
    output logic       bit_done
);

    logic [5:0] edge_cnt;
    logic [5:0] half;
    logic [2:0] samples;

    assign half     = {1'b0, prescale[5:1]};
    assign bit_done = (edge_cnt == prescale - 6'd1);
    assign bit_val  = (samples[0] & samples[1]) |
                      (samples[0] & samples[2]) |
                      (samples[1] & samples[2]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt <= 6'd0;
        end else if (clear || bit_done) begin
            edge_cnt <= 6'd0;
        end else begin
            edge_cnt <= edge_cnt + 6'd1;
        end
    end

    // The three samples straddle mid-bit, well clear of the bit edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            samples <= 3'b111;
        end else if (clear) begin
            samples <= 3'b111;
        end else begin
            if (edge_cnt == half - 6'd1) samples[0] <= rx_in;
            if (edge_cnt == half)        samples[1] <= rx_in;
            if (edge_cnt == half + 6'd1) samples[2] <= rx_in;
        end
    end

endmodule

// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - UART receive framer: start/data/parity/stop with per-frame error flags
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [5:0]            prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stop_err
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    rx_state_t             state;
    rx_state_t             state_next;
    logic [5:0]            p_lat;
    logic                  par_en_lat;
    logic                  par_typ_lat;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  par_bad;
    logic                  bit_val;
    logic                  bit_done;
    logic                  restart;
    logic                  last_data;
    logic                  latch_cfg;
    logic                  shift_en;
    logic                  par_chk;
    logic                  frame_end;
    logic                  frame_good;

    // Idle line keeps the sampler parked; the first low cycle is already edge 0.
    assign restart    = (state == ST_IDLE) && rx_in;
    assign last_data  = (bit_cnt == CNT_W'(DATA_WIDTH - 1));
    assign frame_good = frame_end && bit_val && !par_bad;

    uart_rx_sampler u_sampler (
        .clk      (clk),
        .rst      (rst),
        .rx_in    (rx_in),
        .clear    (restart),
        .prescale (p_lat),
        .bit_val  (bit_val),
        .bit_done (bit_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:   if (!rx_in) state_next = ST_START;
            ST_START:  if (bit_done) state_next = bit_val ? ST_IDLE : ST_DATA;
            ST_DATA:   if (bit_done && last_data) state_next = par_en_lat ? ST_PARITY : ST_STOP;
            ST_PARITY: if (bit_done) state_next = ST_STOP;
            ST_STOP:   if (bit_done) state_next = rx_in ? ST_IDLE : ST_START;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        latch_cfg = 1'b0;
        shift_en  = 1'b0;
        par_chk   = 1'b0;
        frame_end = 1'b0;
        case (state)
            ST_IDLE:   latch_cfg = !rx_in;
            ST_DATA:   shift_en  = bit_done;
            ST_PARITY: par_chk   = bit_done;
            ST_STOP:   frame_end = bit_done;
            default:   ;
        endcase
    end

    // Back-to-back frames entered from STOP reuse the configuration already held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_lat       <= PRESCALE_DEFAULT;
            par_en_lat  <= 1'b0;
            par_typ_lat <= PAR_EVEN;
        end else if (latch_cfg) begin
            p_lat       <= legal_prescale(prescale);
            par_en_lat  <= par_en;
            par_typ_lat <= par_typ;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt <= '0;
        end else if (state != ST_DATA) begin
            bit_cnt <= '0;
        end else if (bit_done) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg <= '0;
        end else if (shift_en) begin
            shift_reg <= {bit_val, shift_reg[DATA_WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_bad <= 1'b0;
        end else if (frame_end) begin
            par_bad <= 1'b0;
        end else if (par_chk) begin
            par_bad <= bit_val != ((^shift_reg) ^ (par_typ_lat == PAR_ODD));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stop_err   <= 1'b0;
        end else begin
            data_valid <= frame_good;
            par_err    <= frame_end && par_bad;
            stop_err   <= frame_end && !bit_val;
            if (frame_good) data_out <= shift_reg;
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb/tb_uart_rx_frame.sv - randomized self-checking bench with frame-level reference model
module tb_uart_rx_frame;

    typedef struct {
        int         cyc;
        bit         dv;
        bit         pe;
        bit         se;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_in;
    logic [5:0] prescale;
    logic       par_en;
    logic       par_typ;
    logic [7:0] data_out;
    logic       data_valid;
    logic       par_err;
    logic       stop_err;

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    ev_t        evq[$];
    logic [7:0] exp_data = 8'h00;
    int         last_dv_cyc = -1, prev_dv_cyc = -1, last_pe_cyc = -1, last_se_cyc = -1;
    int         n_pulses = 0;

    uart_rx_frame #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .prescale   (prescale),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .data_out   (data_out),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stop_err   (stop_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    function automatic int eff_p(input logic [5:0] p);
        return (p == 6'd8 || p == 6'd16 || p == 6'd32) ? int'(p) : 8;
    endfunction

    // Reference: each frame yields exactly one outcome (N = (2+8+par)*P cycles after its start).
    always @(negedge clk) begin
        ev_t e;
        bit  exp_dv, exp_pe, exp_se;
        exp_dv = 1'b0; exp_pe = 1'b0; exp_se = 1'b0;
        if (!rst) begin
            chk("reset_data_out", data_out, 0);
            chk("reset_flags", {data_valid, par_err, stop_err}, 0);
        end else begin
            while (evq.size() > 0 && evq[0].cyc < cyc) begin
                e = evq.pop_front();
                checks++; errors++;
                $display("FAIL event_missed expected at cycle %0d, now %0d", e.cyc, cyc);
            end
            if (evq.size() > 0 && evq[0].cyc == cyc) begin
                e = evq.pop_front();
                exp_dv = e.dv; exp_pe = e.pe; exp_se = e.se;
                if (e.dv) exp_data = e.data;
            end
            chk("data_valid", data_valid, exp_dv);
            chk("par_err", par_err, exp_pe);
            chk("stop_err", stop_err, exp_se);
            chk("data_out", data_out, exp_data);
            if (data_valid) begin prev_dv_cyc = last_dv_cyc; last_dv_cyc = cyc; end
            if (par_err) last_pe_cyc = cyc;
            if (stop_err) last_se_cyc = cyc;
            if (data_valid || par_err || stop_err) n_pulses++;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) tick();
    endtask

    task automatic drive_bit(input logic v, input int p, input bit noisy);
        for (int k = 0; k < p; k++) begin
            rx_in = (noisy && k == p / 2) ? ~v : v;
            tick();
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [5:0] p_in, input bit pe, input bit pt,
                              input bit bad_par, input bit stop_v, input bit noisy, input int mid_p,
                              output int start_cyc);
        int  p;
        ev_t e;
        p = eff_p(p_in);
        prescale = p_in; par_en = pe; par_typ = pt;
        start_cyc = cyc;
        e.cyc  = cyc + (10 + int'(pe)) * p;
        e.pe   = pe && bad_par;
        e.se   = !stop_v;
        e.dv   = !e.pe && !e.se;
        e.data = d;
        evq.push_back(e);
        drive_bit(1'b0, p, 1'b0);
        if (mid_p >= 0) begin
            prescale = 6'(mid_p); par_en = ~pe; par_typ = ~pt;
        end
        for (int i = 0; i < 8; i++) drive_bit(d[i], p, noisy && ($urandom % 2 == 1));
        if (pe) drive_bit((^d) ^ pt ^ bad_par, p, 1'b0);
        drive_bit(stop_v, p, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int         s, s2, p, gap, snap, sel, mid;
        logic [5:0] p_in;
        logic [5:0] plist [7];
        logic [7:0] d;
        plist = '{6'd8, 6'd16, 6'd32, 6'd8, 6'd0, 6'd12, 6'd63};

        rst = 1'b0; rx_in = 1'b1; prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t0_reset_data_out", data_out, 8'h00);
        chk("t0_reset_flags", {data_valid, par_err, stop_err}, 3'b000);
        rst = 1'b1;
        idle(4);

        // 1: P=8 even parity, 0xA5
        send_frame(8'hA5, 6'd8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, -1, s);
        idle(10);
        chk("t1_latency", last_dv_cyc - s, 88);
        chk("t1_data", data_out, 8'hA5);

        // 2: P=16 short glitch on start bit
        snap = n_pulses;
        prescale = 6'd16; par_en = 1'b0;
        rx_in = 1'b0; repeat (3) tick();
        idle(40);
        chk("t2_no_pulse", n_pulses - snap, 0);
        chk("t2_data_held", data_out, 8'hA5);

        // 3: P=8 odd parity, 0x3C sent with parity 0
        send_frame(8'h3C, 6'd8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, -1, s);
        idle(10);
        chk("t3_par_latency", last_pe_cyc - s, 88);
        chk("t3_data_held", data_out, 8'hA5);

        // 4: P=32, 0x81 with stop 0
        send_frame(8'h81, 6'd32, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, s);
        idle(70);
        chk("t4_stop_latency", last_se_cyc - s, 320);

        // 5: back-to-back frames
        send_frame(8'h12, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, s);
        send_frame(8'h34, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, s2);
        idle(10);
        chk("t5_first_latency", prev_dv_cyc - s, 80);
        chk("t5_second_latency", last_dv_cyc - s, 160);
        chk("t5_data", data_out, 8'h34);

        // 6a: prescale moved to 16 during DATA
        send_frame(8'hC3, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16, s);
        idle(10);
        chk("t6_mid_prescale_latency", last_dv_cyc - s, 80);
        chk("t6_mid_prescale_data", data_out, 8'hC3);

        // 6b: reset at data bit 4, then a normal frame
        prescale = 6'd8; par_en = 1'b0;
        drive_bit(1'b0, 8, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(i[0], 8, 1'b0);
        rst = 1'b0; evq.delete(); exp_data = 8'h00;
        tick();
        chk("t6_reset_data", data_out, 8'h00);
        rst = 1'b1;
        idle(16);
        send_frame(8'h5A, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, s);
        idle(10);
        chk("t6_after_reset_data", data_out, 8'h5A);

        // Break: line held low for two frame times, stop_err each frame
        prescale = 6'd8; par_en = 1'b0;
        s = cyc;
        begin
            ev_t e;
            e.dv = 1'b0; e.pe = 1'b0; e.se = 1'b1; e.data = 8'h00;
            e.cyc = s + 80;  evq.push_back(e);
            e.cyc = s + 160; evq.push_back(e);
        end
        rx_in = 1'b0; repeat (160) tick();
        idle(24);
        chk("break_last_stop", last_se_cyc - s, 160);
        chk("break_data_held", data_out, 8'h5A);

        // Randomized frames
        for (int n = 0; n < 40; n++) begin
            sel  = $urandom % 10;
            p_in = plist[$urandom % 7];
            p    = eff_p(p_in);
            if (sel == 0) begin
                prescale = p_in;
                rx_in = 1'b0;
                repeat (1 + $urandom % (p / 2 - 1)) tick();
                idle(2 * p);
            end else begin
                bit pe, pt, bad, sv, noisy;
                d     = 8'($urandom);
                pe    = 1'($urandom % 2);
                pt    = 1'($urandom % 2);
                bad   = ($urandom % 5 == 0);
                sv    = ($urandom % 6 != 0);
                noisy = 1'($urandom % 2);
                mid   = ($urandom % 2 == 1) ? int'($urandom % 64) : -1;
                send_frame(d, p_in, pe, pt, bad, sv, noisy, mid, s);
                gap = sv ? int'($urandom % (2 * p)) : 2 * p;
                idle(gap);
            end
        end
        idle(40);
        chk("all_events_seen", evq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
